// File: rtl/icache_pkg.sv
// Shared types for the I-cache line-fill controller: FSM state encoding and
// the byte-offset width of a cache line.
package icache_pkg;

    typedef enum logic [2:0] {
        INIT,
        CHECK,
        REQ,
        FETCH,
        FILL
    } state_t;

    function automatic int off_w(input int line_words, input int data_w);
        return $clog2(line_words) + $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/icache_line_buf.sv
// Line buffer: collects memory beats in ascending word order and flags the final beat.
// The write is one cycle after the beat. No backpressure: every valid beat is stored.
module icache_line_buf #(
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_start,
    input  logic                         i_beat_vld,
    input  logic [DATA_W-1:0]            i_beat_dat,
    output logic [LINE_WORDS*DATA_W-1:0] o_line,
    output logic                         o_last
);

    localparam int CNT_W = $clog2(LINE_WORDS);

    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_words [LINE_WORDS];

    // The counter is a power-of-two width, so it wraps back to 0 after the last word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_cnt <= '0;
        end else if (i_beat_vld) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_beat_vld) begin
            r_words[r_cnt] <= i_beat_dat;
        end
    end

    assign o_last = i_beat_vld && (r_cnt == CNT_W'(LINE_WORDS - 1));

    for (genvar k = 0; k < LINE_WORDS; k++) begin : g_line
        assign o_line[k*DATA_W +: DATA_W] = r_words[k];
    end

endmodule

// File: rtl/icache_fill_ctrl.sv
// I-cache miss/line-fill controller. Fetch stalls while a line burst is gathered and written in one cycle.
// A flush is deferred until any fill finishes. Optional perf counters are enabled by `ICACHE_PERF_EN.
module icache_fill_ctrl
    import icache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cpu_re,
    input  logic [ADDR_W-1:0]            cpu_addr,
    input  logic                         hit,
    input  logic                         flush,
    output logic                         stall,
    output logic                         clr,
    output logic                         mm_req,
    output logic [ADDR_W-1:0]            mm_addr,
    input  logic                         mm_ready,
    input  logic                         mm_valid,
    input  logic [DATA_W-1:0]            mm_data,
    output logic                         fill_we,
    output logic [ADDR_W-1:0]            fill_addr,
    output logic [LINE_WORDS*DATA_W-1:0] fill_line,
    output logic [31:0]                  hit_cnt,
    output logic [31:0]                  miss_cnt
);

    localparam int OFF = off_w(LINE_WORDS, DATA_W);
    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFF){1'b1}}, {OFF{1'b0}}};

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_flush_pend;
    logic              w_flush_pend_nxt;
    logic [ADDR_W-1:0] r_miss_addr;
    logic              w_miss;
    logic              w_start;
    logic              w_beat_vld;
    logic              w_last;

    assign w_miss     = cpu_re & ~hit;
    assign w_beat_vld = mm_valid & (r_state == FETCH);

    always_comb begin
        w_state_nxt      = r_state;
        w_flush_pend_nxt = r_flush_pend;
        w_start          = 1'b0;
        stall            = 1'b1;
        clr              = 1'b0;
        mm_req           = 1'b0;
        fill_we          = 1'b0;
        case (r_state)
            INIT: begin
                clr         = 1'b1;
                w_state_nxt = CHECK;
            end
            CHECK: begin
                stall = w_miss;
                if (flush) begin
                    w_state_nxt = INIT;
                end else if (w_miss) begin
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                mm_req = 1'b1;
                if (flush) w_flush_pend_nxt = 1'b1;
                if (mm_ready) begin
                    w_start     = 1'b1;
                    w_state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (flush) w_flush_pend_nxt = 1'b1;
                if (w_last) w_state_nxt = FILL;
            end
            FILL: begin
                fill_we = 1'b1;
                // A flush arriving in the write cycle itself is honoured right away.
                if (r_flush_pend || flush) begin
                    w_flush_pend_nxt = 1'b0;
                    w_state_nxt      = INIT;
                end else begin
                    w_state_nxt = CHECK;
                end
            end
            default: w_state_nxt = INIT;
        endcase
        if (reset) begin
            stall   = 1'b1;
            clr     = 1'b1;
            mm_req  = 1'b0;
            fill_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= INIT;
            r_flush_pend <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_flush_pend <= w_flush_pend_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_miss_addr <= '0;
        end else if (r_state == CHECK && w_miss) begin
            r_miss_addr <= cpu_addr & LINE_MASK;
        end
    end

    icache_line_buf #(
        .DATA_W     (DATA_W),
        .LINE_WORDS (LINE_WORDS)
    ) u_line_buf (
        .clk        (clk),
        .reset      (reset),
        .i_start    (w_start),
        .i_beat_vld (w_beat_vld),
        .i_beat_dat (mm_data),
        .o_line     (fill_line),
        .o_last     (w_last)
    );

    assign mm_addr   = r_miss_addr;
    assign fill_addr = r_miss_addr;

`ifdef ICACHE_PERF_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (r_state == CHECK && cpu_re && hit && r_hit_cnt != '1) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (r_state == CHECK && w_state_nxt == REQ && r_miss_cnt != '1) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed bench for icache_fill_ctrl: reset, hits, gapped fill, deferred flush,
// reset mid-fill and the optional performance counters.
module tb_icache_fill_ctrl;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int LINE_WORDS = 8;

    logic                         clk = 1'b0;
    logic                         reset;
    logic                         cpu_re;
    logic [ADDR_W-1:0]            cpu_addr;
    logic                         hit;
    logic                         flush;
    logic                         stall;
    logic                         clr;
    logic                         mm_req;
    logic [ADDR_W-1:0]            mm_addr;
    logic                         mm_ready;
    logic                         mm_valid;
    logic [DATA_W-1:0]            mm_data;
    logic                         fill_we;
    logic [ADDR_W-1:0]            fill_addr;
    logic [LINE_WORDS*DATA_W-1:0] fill_line;
    logic [31:0]                  hit_cnt;
    logic [31:0]                  miss_cnt;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    icache_fill_ctrl #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .LINE_WORDS (LINE_WORDS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_re    (cpu_re),
        .cpu_addr  (cpu_addr),
        .hit       (hit),
        .flush     (flush),
        .stall     (stall),
        .clr       (clr),
        .mm_req    (mm_req),
        .mm_addr   (mm_addr),
        .mm_ready  (mm_ready),
        .mm_valid  (mm_valid),
        .mm_data   (mm_data),
        .fill_we   (fill_we),
        .fill_addr (fill_addr),
        .fill_line (fill_line),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // From CHECK: raise a miss, memory accepts on the first REQ cycle; returns in FETCH.
    task automatic start_miss(input logic [ADDR_W-1:0] addr, input logic [ADDR_W-1:0] base);
        cpu_re = 1'b1; hit = 1'b0; cpu_addr = addr;
        mid();
        check("miss_stall", stall, 1);
        adv();
        mm_ready = 1'b1;
        mid();
        check("req_mm_req", mm_req, 1);
        check("req_mm_addr", mm_addr, base);
        adv();
        mm_ready = 1'b0;
    endtask

    task automatic feed_beats(input logic [DATA_W-1:0] d0, input int n, input int flush_at);
        for (int i = 0; i < n; i++) begin
            mm_valid = 1'b1;
            mm_data  = d0 + DATA_W'(i);
            flush    = (i == flush_at);
            mid();
            check("fetch_stall", stall, 1);
            check("fetch_no_we", fill_we, 0);
            adv();
        end
        mm_valid = 1'b0;
        flush    = 1'b0;
    endtask

    // Called on the FILL cycle's falling edge.
    task automatic check_fill(input logic [ADDR_W-1:0] base, input logic [DATA_W-1:0] d0);
        check("fill_we", fill_we, 1);
        check("fill_stall", stall, 1);
        check("fill_addr", fill_addr, base);
        for (int k = 0; k < LINE_WORDS; k++) begin
            check("fill_word", fill_line[k*DATA_W +: DATA_W], d0 + DATA_W'(k));
        end
    endtask

    logic beat_pat [10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        int b;
        reset = 1'b1; cpu_re = 1'b0; cpu_addr = '0; hit = 1'b0; flush = 1'b0;
        mm_ready = 1'b0; mm_valid = 1'b0; mm_data = '0;

        // 1: reset for two edges, then release
        adv();
        mid();
        check("rst_clr", clr, 1);
        check("rst_stall", stall, 1);
        check("rst_mm_req", mm_req, 0);
        check("rst_fill_we", fill_we, 0);
        check("rst_hit_cnt", hit_cnt, 0);
        check("rst_miss_cnt", miss_cnt, 0);
        adv();
        reset = 1'b0;
        mid();
        check("post_rst_clr", clr, 1);
        check("post_rst_stall", stall, 1);
        adv();
        mid();
        check("check_clr", clr, 0);
        check("idle_stall", stall, 0);
        adv();

        // 2: hits never stall and never request memory
        cpu_re = 1'b1; hit = 1'b1; cpu_addr = 32'h0000_0100;
        for (int i = 0; i < 4; i++) begin
            mid();
            check("hit_stall", stall, 0);
            check("hit_mm_req", mm_req, 0);
            adv();
        end

        // 3: miss at 0x1234, memory ready after 3 cycles, gapped beats
        cpu_addr = 32'h0000_1234; hit = 1'b0;
        mid();
        check("miss3_stall", stall, 1);
        check("miss3_no_req", mm_req, 0);
        adv();
        for (int i = 0; i < 3; i++) begin
            mid();
            check("req3_mm_req", mm_req, 1);
            check("req3_mm_addr", mm_addr, 32'h0000_1220);
            check("req3_stall", stall, 1);
            adv();
        end
        mm_ready = 1'b1; mm_valid = 1'b1; mm_data = 32'hDEAD_BEEF;
        mid();
        check("req3_accept", mm_req, 1);
        adv();
        mm_ready = 1'b0;
        b = 0;
        for (int i = 0; i < 10; i++) begin
            mm_valid = beat_pat[i];
            mm_data  = beat_pat[i] ? 32'hA0 + DATA_W'(b) : 32'h5555_5555;
            if (beat_pat[i]) b++;
            mid();
            check("fetch3_stall", stall, 1);
            check("fetch3_no_req", mm_req, 0);
            check("fetch3_no_we", fill_we, 0);
            adv();
        end
        mm_valid = 1'b0; hit = 1'b1;
        mid();
        check_fill(32'h0000_1220, 32'hA0);
        adv();
        mid();
        check("after_fill_we", fill_we, 0);
        check("after_fill_stall", stall, 0);
        adv();

        // 4: flush during FETCH is deferred until the fill is written
        start_miss(32'h0000_2008, 32'h0000_2000);
        feed_beats(32'hB0, 8, 2);
        cpu_re = 1'b0;
        mid();
        check_fill(32'h0000_2000, 32'hB0);
        check("flush_fill_clr", clr, 0);
        adv();
        mid();
        check("flush_init_clr", clr, 1);
        check("flush_init_stall", stall, 1);
        check("flush_init_we", fill_we, 0);
        adv();
        mid();
        check("flush_check_clr", clr, 0);
        check("flush_check_stall", stall, 0);
        adv();

        // 5: reset on beat 3 discards the partial line
        start_miss(32'h0000_3010, 32'h0000_3000);
        feed_beats(32'hC0, 3, -1);
        reset = 1'b1; mm_valid = 1'b1; mm_data = 32'hC3;
        mid();
        check("midrst_clr_now", clr, 1);
        check("midrst_req_now", mm_req, 0);
        adv();
        reset = 1'b0; mm_valid = 1'b0; cpu_re = 1'b0;
        mid();
        check("midrst_mm_req", mm_req, 0);
        check("midrst_clr", clr, 1);
        check("midrst_fill_we", fill_we, 0);
        adv();
        for (int i = 0; i < 2; i++) begin
            mid();
            check("midrst_idle_we", fill_we, 0);
            check("midrst_idle_req", mm_req, 0);
            adv();
        end
        start_miss(32'h0000_3010, 32'h0000_3000);
        feed_beats(32'hD0, 8, -1);
        cpu_re = 1'b0;
        mid();
        check_fill(32'h0000_3000, 32'hD0);
        adv();

        // 6: counters after a fresh reset: 5 hits, 2 misses
        reset = 1'b1;
        adv();
        reset = 1'b0;
        mid();
        check("perf_rst_hit", hit_cnt, 0);
        check("perf_rst_miss", miss_cnt, 0);
        adv();
        cpu_re = 1'b1; hit = 1'b1; cpu_addr = 32'h0000_0040;
        for (int i = 0; i < 5; i++) adv();
        for (int m = 0; m < 2; m++) begin
            start_miss(32'h0000_4000 + ADDR_W'(m * 32), 32'h0000_4000 + ADDR_W'(m * 32));
            feed_beats(32'hE0 + DATA_W'(m * 16), 8, -1);
            cpu_re = 1'b0;
            mid();
            check("perf_fill_we", fill_we, 1);
            adv();
        end
        mid();
`ifdef ICACHE_PERF_EN
        check("perf_hit_cnt", hit_cnt, 5);
        check("perf_miss_cnt", miss_cnt, 2);
`else
        check("perf_hit_cnt", hit_cnt, 0);
        check("perf_miss_cnt", miss_cnt, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d of %0d checks", n_err, n_chk);
        $fatal(1);
    end

endmodule
